// File: rtl/conv1_seq.sv
// conv1_seq: frame sequencer for the first convolution layer.
// Reads one WIDTH x HEIGHT frame from a single-port image RAM (1-cycle read latency) and streams it
// to the conv1 datapath. It then counts datapath outputs until the frame completes or the datapath
// goes quiet.
module conv1_seq #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned HEIGHT    = 36,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [DATA_BITS-1:0] feed_data,
  output logic                 feed_valid,
  input  logic                 conv_valid,
  output logic [9:0]           out_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned          Total    = WIDTH * HEIGHT;
  localparam int unsigned          Expected = (WIDTH - 2) * (HEIGHT - 2);
  localparam logic [ADDR_BITS-1:0] LastPix  = ADDR_BITS'(Total - 1);
  localparam logic [9:0]           ExpCount = 10'(Expected);
  localparam logic [9:0]           CountMax = 10'd1023;
  localparam int unsigned          TmoBits  = $clog2(TIMEOUT + 1);
  // Firing one count early lands the done cycle exactly TIMEOUT cycles after the last output.
  localparam logic [TmoBits-1:0]   TmoFire  = TmoBits'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pix_cnt_q, pix_cnt_d;
  logic [TmoBits-1:0]   tmo_q, tmo_d;
  logic [9:0]           out_count_q, out_count_d;
  logic                 error_q, error_d;
  logic                 feed_valid_q, feed_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state decode, counters and the combinational RAM read request.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    tmo_d       = tmo_q;
    out_count_d = out_count_q;
    error_d     = error_q;
    rd_en       = 1'b0;
    rd_addr     = '0;

    // Count datapath outputs only while a frame is live; one beyond the expected total is an error.
    if ((state_q == StFeed || state_q == StDrain) && conv_valid) begin
      if (out_count_q == ExpCount) begin
        error_d = 1'b1;
      end else if (out_count_q != CountMax) begin
        out_count_d = out_count_q + 10'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFeed;
          pix_cnt_d   = '0;
          tmo_d       = '0;
          out_count_d = '0;
          error_d     = 1'b0;
        end
      end
      StFeed: begin
        if (!pause) begin
          rd_en     = 1'b1;
          rd_addr   = pix_cnt_q;
          pix_cnt_d = pix_cnt_q + ADDR_BITS'(1);
          if (pix_cnt_q == LastPix) state_d = StDrain;
        end
      end
      StDrain: begin
        tmo_d = conv_valid ? '0 : tmo_q + TmoBits'(1);
        if (out_count_d == ExpCount) begin
          state_d = StDone;
        end else if (!conv_valid && tmo_d == TmoFire) begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    feed_valid_d = rd_en;
    busy_d       = (state_d == StFeed) || (state_d == StDrain);
    done_d       = (state_d == StDone);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pix_cnt_q    <= '0;
      tmo_q        <= '0;
      out_count_q  <= '0;
      error_q      <= 1'b0;
      feed_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      tmo_q        <= tmo_d;
      out_count_q  <= out_count_d;
      error_q      <= error_d;
      feed_valid_q <= feed_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign feed_data  = rd_data;
  assign feed_valid = feed_valid_q;
  assign out_count  = out_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_conv1_seq.sv
// Bench for conv1_seq: a table of whole-frame scenarios with an address/data scoreboard, plus
// hand-written reset sequences.
module tb_conv1_seq;

  localparam int unsigned WIDTH      = 28;
  localparam int unsigned HEIGHT     = 36;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned ADDR_BITS  = 10;
  localparam int unsigned TIMEOUT    = 64;
  localparam int          Total      = 1008;
  localparam int          Expected   = 884;
  localparam int          FrameLimit = 2500;

  logic                 clk = 1'b0;
  logic                 rst_n, start, pause, conv_valid;
  logic                 rd_en, feed_valid, busy, done, error;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data, feed_data;
  logic [9:0]           out_count;

  int total = 0;
  int bad   = 0;
  int cur   = -1;

  always #5 clk = ~clk;

  conv1_seq #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .feed_data (feed_data),
    .feed_valid(feed_valid),
    .conv_valid(conv_valid),
    .out_count (out_count),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Image RAM model: returns the address as data one cycle after a read, poison otherwise.
  always @(posedge clk) rd_data <= rd_en ? DATA_BITS'(rd_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL scen=%0d %s: got %0d expected %0d (t=%0t)", cur, name, act, exp, $time);
    end
  endtask

  typedef struct {
    int conv_start;
    int conv_num;
    int conv_period;
    bit pause_on;
    bit start_mid;
    bit start_done;
    int exp_count;
    bit exp_err;
    int err_pulse;  // pulse index (1-based) that must raise error, 0 = none
    bit tmo;        // frame must end by timeout
  } scen_t;

  scen_t tbl[5];

  task automatic idle_checks(input int n, input int exp_cnt, input bit exp_err);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start      = 1'b0;
      conv_valid = 1'b1;  // must be ignored in IDLE
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rd_en", rd_en, 0);
      check("idle_feed_valid", feed_valid, 0);
      check("idle_out_count", out_count, exp_cnt);
      check("idle_error", error, exp_err);
    end
    @(negedge clk);
    conv_valid = 1'b0;
  endtask

  task automatic run_frame(input scen_t s, input int rst_at, output bit aborted);
    int  model_addr, last_read_f, reach_f, last_conv_f, err_pulse_f, done_f, err_f, pulses, n_rd;
    int  exp_done, exp_err_f, cnt_at_done;
    bit  exp_rd, exp_fv, done_seen, err_at_done;
    logic [ADDR_BITS-1:0] exp_a;
    logic [ADDR_BITS-1:0] addr_q[$];
    logic [DATA_BITS-1:0] data_q[$];

    model_addr = 0; last_read_f = -1; reach_f = -1; last_conv_f = -1; err_pulse_f = -1;
    done_f = -1; err_f = -1; pulses = 0; n_rd = 0; exp_fv = 1'b0; done_seen = 1'b0;
    aborted = 1'b0; cnt_at_done = -1; err_at_done = 1'b0;

    // Start cycle; pause in the same cycle must not block the transition.
    @(negedge clk);
    start      = 1'b1;
    pause      = s.pause_on;
    conv_valid = 1'b0;
    #1;
    check("start_cycle_rd_en", rd_en, 0);

    for (int f = 0; f < FrameLimit && !done_seen && !aborted; f++) begin
      @(negedge clk);
      start      = s.start_mid && (f == 100);
      pause      = s.pause_on && ((f >= 10 && f <= 14) ||
                   (model_addr >= 140 && model_addr < 196 && (f % 2) == 1));
      conv_valid = (f >= s.conv_start) && (pulses < s.conv_num) &&
                   ((f - s.conv_start) % s.conv_period == 0);
      if (rst_at >= 0 && model_addr == rst_at) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end else begin
        exp_rd = (model_addr < Total) && !pause;
        if (exp_rd) begin
          addr_q.push_back(ADDR_BITS'(model_addr));
          if (model_addr == Total - 1) last_read_f = f;
          model_addr++;
        end
        if (conv_valid) begin
          pulses++;
          last_conv_f = f;
          if (pulses == Expected) reach_f = f;
          if (pulses == s.err_pulse) err_pulse_f = f;
        end
        #1;
        if (f == 0) begin
          check("start_clears_count", out_count, 0);
          check("start_clears_error", error, 0);
        end
        check("rd_en", rd_en, exp_rd);
        if (rd_en) begin
          n_rd++;
          if (addr_q.size() > 0) begin
            exp_a = addr_q.pop_front();
            check("rd_addr", rd_addr, exp_a);
            data_q.push_back(DATA_BITS'(exp_a));
          end
        end
        check("feed_valid", feed_valid, exp_fv);
        if (feed_valid && data_q.size() > 0) check("feed_data", feed_data, data_q.pop_front());
        exp_fv = exp_rd;
        if (error && err_f < 0) err_f = f;
        if (done) begin
          done_seen   = 1'b1;
          done_f      = f;
          cnt_at_done = out_count;
          err_at_done = error;
          check("busy_at_done", busy, 0);
          if (s.start_done) start = 1'b1;  // start during DONE must be ignored
        end else begin
          check("busy_in_frame", busy, 1);
        end
      end
    end

    if (!aborted) begin
      check("done_seen", done_seen, 1);
      if (s.tmo) exp_done = last_conv_f + TIMEOUT;
      else if (reach_f > last_read_f) exp_done = reach_f + 1;
      else exp_done = last_read_f + 2;
      if (s.err_pulse != 0) exp_err_f = err_pulse_f + 1;
      else if (s.tmo) exp_err_f = exp_done;
      else exp_err_f = -1;
      check("done_cycle", done_f, exp_done);
      check("read_count", n_rd, Total);
      check("scoreboard_left", addr_q.size() + data_q.size(), 0);
      check("count_at_done", cnt_at_done, s.exp_count);
      check("error_at_done", err_at_done, s.exp_err);
      check("error_rise_cycle", err_f, exp_err_f);
      idle_checks(3, s.exp_count, s.exp_err);
    end
  endtask

  bit ab;

  initial begin
    //             cstart cnum per pause mid  done cnt  err  errp tmo
    tbl[0] = '{200, 884, 1, 1'b0, 1'b0, 1'b0, 884, 1'b0, 0,   1'b0};  // nominal
    tbl[1] = '{300, 884, 1, 1'b1, 1'b0, 1'b0, 884, 1'b0, 0,   1'b0};  // pause gaps
    tbl[2] = '{300, 800, 2, 1'b0, 1'b0, 1'b0, 800, 1'b1, 0,   1'b1};  // timeout
    tbl[3] = '{50,  885, 1, 1'b0, 1'b0, 1'b0, 884, 1'b1, 885, 1'b0};  // over-count
    tbl[4] = '{0,   884, 1, 1'b0, 1'b1, 1'b1, 884, 1'b0, 0,   1'b0};  // start while busy

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; conv_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_feed_valid", feed_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_checks(2, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cur = i;
      run_frame(tbl[i], -1, ab);
    end

    // Reset in the middle of a frame, then a clean frame must follow from address 0.
    cur = 5;
    run_frame(tbl[0], 500, ab);
    check("reset_abort_taken", ab, 1);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; pause = 1'b0; conv_valid = 1'b0;
    #1;
    check("midrst_rd_en", rd_en, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_feed_valid", feed_valid, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    cur = 6;
    run_frame(tbl[0], -1, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1_seq.md
Name: conv1_seq

Overview:
Frame sequencer for the first convolution layer. On a start pulse it reads one WIDTH x HEIGHT input frame, pixel by pixel, from a single-port image RAM with 1-cycle read latency. It streams those pixels into the conv1 datapath as data/valid, then counts the datapath's valid outputs until the frame is complete. It reports busy, done and error to the network-level controller and supports a feed pause for upstream arbitration.

Parameters:
WIDTH, 28, input frame width in pixels
HEIGHT, 36, input frame height in pixels
DATA_BITS, 32, pixel word width
ADDR_BITS, 10, image RAM address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT
TIMEOUT, 64, max idle cycles allowed between datapath outputs in DRAIN
Derived: TOTAL = WIDTH*HEIGHT (1008); EXPECTED = (WIDTH-2)*(HEIGHT-2) (884)

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle frame start request
pause  in  1  1 = hold feed (no new RAM read this cycle)
rd_en  out  1  image RAM read enable
rd_addr  out  ADDR_BITS  image RAM read address
rd_data  in  DATA_BITS  RAM read data, valid 1 cycle after rd_en
feed_data  out  DATA_BITS  pixel to conv1 datapath (= rd_data, pass-through)
feed_valid  out  1  pixel valid to conv1 datapath
conv_valid  in  1  conv1 datapath output-valid strobe
out_count  out  10  datapath outputs counted this frame
busy  out  1  high in FEED and DRAIN
done  out  1  single-cycle pulse at frame end (normal or error)
error  out  1  sticky error flag, cleared by the next accepted start

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. rd_en=0, rd_addr=0, feed_valid=0, out_count=0, busy=0, done=0, error=0. Pixel and timeout counters are 0. Applies from any state, mid-frame included; no partial frame resumes.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 moves to FEED on the next edge. The same edge clears out_count, error, the pixel counter and the timeout counter. conv_valid in IDLE is ignored and not counted.
- FEED:
  - Each cycle with pause=0: rd_en=1, rd_addr=pix_cnt, pix_cnt increments.
  - With pause=1: rd_en=0, pix_cnt holds.
  - rd_en and rd_addr are combinational from state, pause and pix_cnt.
  - After the read with pix_cnt==TOTAL-1 is issued, go to DRAIN.
- feed_valid is rd_en registered by one cycle, in all states. feed_data = rd_data, so it is aligned with feed_valid. The last pixel's feed_valid therefore occurs in the first DRAIN cycle.
- Output counting: in FEED and DRAIN, each conv_valid=1 increments out_count. The counter saturates at 1023.
- DRAIN:
  - rd_en=0.
  - The timeout counter resets to 0 on any cycle with conv_valid=1 and increments otherwise.
  - If the count reaches EXPECTED (including on this cycle's conv_valid), go to DONE.
  - If the timeout counter reaches TIMEOUT first, set error=1 and go to DONE.
- DONE: one cycle. done=1, busy=0. Returns to IDLE next edge.
- Over-count: conv_valid arriving while out_count==EXPECTED in FEED or DRAIN sets error=1. A conv_valid arriving in the same cycle as the DONE state is ignored.
- start while busy or in DONE: ignored, no effect on state or counters.
- start and pause in the same IDLE cycle: the transition to FEED occurs; pause only gates reads in FEED.
- busy is registered from the next-state decode: busy=1 exactly in FEED/DRAIN cycles.
- done is registered: it is high exactly in the DONE cycle.
- Latency: the first rd_en is asserted in the cycle after start is sampled. With no pause, the last read issues TOTAL cycles after entering FEED.

Test Plan:
1. Nominal frame:
   - Stimulus: reset, then start; RAM model returns data=address; conv model emits EXPECTED conv_valid pulses spread over FEED/DRAIN.
   - Required: 1008 rd_en cycles, addresses 0..1007 in order; feed_valid trails rd_en by exactly 1 with feed_data=address; out_count=884; one done pulse; error=0; busy falls with done.
2. Pause:
   - Stimulus: assert pause for cycles 10-14 of FEED and on every other cycle of rows 5-6.
   - Required: no rd_en while paused; address sequence still contiguous 0..1007 with no skips or repeats; feed_valid gaps match the pause gaps shifted by 1 cycle.
3. Timeout:
   - Stimulus: conv model stops after 800 outputs.
   - Required: error=1 and a done pulse exactly TIMEOUT=64 cycles after the last conv_valid; out_count=800; error stays 1 until the next start, then clears.
4. Over-count:
   - Stimulus: conv model emits 885 pulses before DONE.
   - Required: error=1 set on the 885th pulse; out_count=884; done still pulses once.
5. Start while busy:
   - Stimulus: pulse start at FEED cycle 100 and again in the DONE cycle.
   - Required: no address restart, counters undisturbed, a single done pulse; a start in IDLE afterwards begins a new frame from address 0.
6. Reset mid-frame:
   - Stimulus: rst_n=0 for 1 cycle at pixel 500.
   - Required: the next cycle shows all outputs at reset values and state IDLE; a following start reads from address 0 and completes normally with out_count=884.
